// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, transmitter FSM states, legal frame widths.
// Used by both the transmitter and the paired receiver.
package uart_pkg;
  localparam int DATA_W_MIN = 5;
  localparam int DATA_W_MAX = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;
endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one tick every div+1 clk cycles, counter held at 0 while clear.
// Shared with the receiver.
module uart_baud_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;

  assign tick = !clear && (cnt == div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear || tick) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, DATA_W data bits LSB first, optional parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input (line break hold while idle).
module uart_tx_framed
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic [1:0]        parity_mode,
  input  logic              two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic              brk,
`endif
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);
  localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int IDX_W = $clog2(DATA_W);

  tx_state_e         state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [OS_W-1:0]   os_cnt, os_cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic              par_en_q, par_en_n, par_q, par_n;
  logic              two_q, two_n, stop2_q, stop2_n;
  logic              tx_n, done_n, tick, accept, bit_end, brk_i;

`ifdef UART_TX_BREAK_EN
  assign brk_i = brk;
`else
  assign brk_i = 1'b0;
`endif

  assign in_ready = (state == IDLE) && !brk_i;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;
  assign bit_end  = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (state == IDLE),
    .div   (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    div_n    = div_q;
    par_en_n = par_en_q;
    par_n    = par_q;
    two_n    = two_q;
    stop2_n  = stop2_q;
    idx_n    = idx;
    tx_n     = tx;
    done_n   = 1'b0;
    if (state == IDLE)  os_cnt_n = '0;
    else if (bit_end)   os_cnt_n = '0;
    else if (tick)      os_cnt_n = os_cnt + 1'b1;
    else                os_cnt_n = os_cnt;

    case (state)
      IDLE: begin
        tx_n = !brk_i;
        if (accept) begin
          state_n  = START;
          tx_n     = 1'b0;
          shreg_n  = in_data;
          div_n    = baud_div;
          two_n    = two_stop;
          par_en_n = (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
          par_n    = (^in_data) ^ (parity_mode == PAR_ODD);
        end
      end
      START: if (bit_end) begin
        // shreg[0] always holds the next data bit to drive
        state_n = DATA;
        idx_n   = '0;
        tx_n    = shreg[0];
        shreg_n = shreg >> 1;
      end
      DATA: if (bit_end) begin
        if (idx == IDX_W'(DATA_W - 1)) begin
          stop2_n = 1'b0;
          if (par_en_q) begin
            state_n = PARITY;
            tx_n    = par_q;
          end else begin
            state_n = STOP;
            tx_n    = 1'b1;
          end
        end else begin
          idx_n   = idx + 1'b1;
          tx_n    = shreg[0];
          shreg_n = shreg >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n    = 1'b1;
      end
      STOP: if (bit_end) begin
        if (two_q && !stop2_q) begin
          stop2_n = 1'b1;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      div_q    <= '0;
      os_cnt   <= '0;
      idx      <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      two_q    <= 1'b0;
      stop2_q  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      div_q    <= div_n;
      os_cnt   <= os_cnt_n;
      idx      <= idx_n;
      par_en_q <= par_en_n;
      par_q    <= par_n;
      two_q    <= two_n;
      stop2_q  <= stop2_n;
      tx       <= tx_n;
      tx_done  <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Randomized and directed checks of uart_tx_framed against a per-cycle frame waveform model.
module tb_uart_tx_framed;
  localparam int DW = 8;
  localparam int OS = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_ready;
  logic [15:0]   baud_div;
  logic [1:0]    parity_mode;
  logic          two_stop, tx, busy, tx_done, brk;

  int errors = 0;
  int checks = 0;
  logic obs [0:511];
  int done_at;

  always #5 clk = ~clk;

  uart_tx_framed #(.DATA_W(DW), .OVERSAMPLE(OS), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .baud_div(baud_div), .parity_mode(parity_mode), .two_stop(two_stop),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx(tx), .busy(busy), .tx_done(tx_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic logic [15:0] frame_bits(input logic [DW-1:0] d, input logic [1:0] pm,
                                             input logic two, output int n);
    logic [15:0] b;
    b = '0;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < DW; i++) begin b[n] = d[i]; n++; end
    if (pm == 2'b01)      begin b[n] = ^d;  n++; end
    else if (pm == 2'b10) begin b[n] = ~^d; n++; end
    b[n] = 1'b1; n++;
    if (two) begin b[n] = 1'b1; n++; end
    return b;
  endfunction

  task automatic send_frame(input string tag, input logic [DW-1:0] d, input logic [1:0] pm,
                            input logic two, input logic [15:0] div, input logic mid,
                            input int brk_k);
    logic [15:0] fb;
    int n, per, len, werr, hviol, dcnt;
    fb  = frame_bits(d, pm, two, n);
    per = OS * (int'(div) + 1);
    len = n * per;
    chk({tag, "_ready"}, in_ready, 1);
    in_data = d; parity_mode = pm; two_stop = two; baud_div = div; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    werr = 0; hviol = 0; dcnt = 0; done_at = -1;
    for (int k = 0; k <= len + 1; k++) begin
      if (k > 0) @(negedge clk);
      obs[k] = tx;
      if (k < len) begin
        if (tx !== fb[k / per]) werr++;
        if (in_ready !== 1'b0 || busy !== 1'b1) hviol++;
      end else if (k == len) begin
        if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== !brk) hviol++;
      end else if (tx !== !brk) werr++;
      if (tx_done === 1'b1) begin
        dcnt++;
        if (done_at < 0) done_at = k;
      end
      if (mid && k == 10) begin
        baud_div = 16'd5; parity_mode = ~pm; two_stop = ~two; in_data = ~d;
      end
      if (k == brk_k) brk = 1'b1;
    end
    chk({tag, "_wave"}, werr, 0);
    chk({tag, "_hs"}, hviol, 0);
    chk({tag, "_len"}, done_at, len);
    chk({tag, "_pulses"}, dcnt, 1);
  endtask

  initial begin
    logic [9:0]  a5_exp;
    logic [15:0] f1, f2;
    int n1, n2, werr, dcnt, d1, d2, len, bad;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; baud_div = 16'd1;
    parity_mode = 2'b00; two_stop = 1'b0; brk = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5, no parity, 1 stop, 8 clk per bit
    send_frame("a5", 8'hA5, 2'b00, 1'b0, 16'd1, 1'b0, -1);
    a5_exp = 10'b1101001010;
    bad = 0;
    for (int b = 0; b < 10; b++) if (obs[b*8+4] !== a5_exp[b]) bad++;
    chk("a5_bits", bad, 0);
    chk("a5_80clk", done_at, 80);

    send_frame("even07", 8'h07, 2'b01, 1'b0, 16'd1, 1'b0, -1);
    chk("even07_par", obs[76], 1);
    chk("even07_88clk", done_at, 88);
    send_frame("odd03", 8'h03, 2'b10, 1'b0, 16'd1, 1'b0, -1);
    chk("odd03_par", obs[76], 1);
    send_frame("odd07", 8'h07, 2'b10, 1'b0, 16'd1, 1'b0, -1);
    chk("odd07_par", obs[76], 0);
    send_frame("ff2stop", 8'hFF, 2'b00, 1'b1, 16'd0, 1'b1, -1);
    chk("ff2stop_44clk", done_at, 44);

    // back-to-back with in_valid held high
    f1 = frame_bits(8'h11, 2'b00, 1'b0, n1);
    f2 = frame_bits(8'h22, 2'b00, 1'b0, n2);
    len = n1 * 8;
    in_data = 8'h11; parity_mode = 2'b00; two_stop = 1'b0; baud_div = 16'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_data = 8'h22;
    werr = 0; dcnt = 0; d1 = -1; d2 = -1;
    for (int k = 0; k <= 2*len + 2; k++) begin
      if (k > 0) @(negedge clk);
      if (k < len)         begin if (tx !== f1[k/8]) werr++; end
      else if (k == len)   begin if (tx !== 1'b1) werr++; end
      else if (k <= 2*len) begin if (tx !== f2[(k-len-1)/8]) werr++; end
      else if (tx !== 1'b1) werr++;
      if (tx_done === 1'b1) begin
        dcnt++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
      if (k == len + 1) in_valid = 1'b0;
    end
    chk("b2b_wave", werr, 0);
    chk("b2b_pulses", dcnt, 2);
    chk("b2b_done1", d1, len);
    chk("b2b_done2", d2, 2*len + 1);

    // reset during data bit 3 of a frame
    in_data = 8'hA5; parity_mode = 2'b00; two_stop = 1'b0; baud_div = 16'd1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (35) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame("after_rst5a", 8'h5A, 2'b00, 1'b0, 16'd1, 1'b0, -1);

    for (int i = 0; i < 10; i++)
      send_frame($sformatf("rnd%0d", i), DW'($urandom), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), -1);

`ifdef UART_TX_BREAK_EN
    brk = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (tx !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("brk_idle", bad, 0);
    brk = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("brk_release", tx, 1);
    send_frame("brk_mid", 8'h3C, 2'b01, 1'b0, 16'd1, 1'b0, 20);
    @(negedge clk);
    chk("brk_after_frame", tx, 0);
    brk = 1'b0;
    @(negedge clk);
    chk("brk_end", tx, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_framed.md
Name: uart_tx_framed

Overview:
- Parametrised second-generation UART transmitter.
- Accepts words over a valid/ready handshake and serialises them LSB-first on `tx`.
- Internal runtime-programmable baud divider.
- Per-frame selectable parity (none/even/odd) and 1 or 2 stop bits.
- Sits between the host-side command/response logic and the board TX pin; the pair receiver block shares its package.

Parameters:
- DATA_W, 8: data bits per frame; legal 5..9.
- OVERSAMPLE, 16: baud ticks per bit period; ≥1.
- DIV_W, 16: width of the `baud_div` input.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_data  in  DATA_W  word to transmit
- in_valid  in  1  word present
- in_ready  out  1  block can accept; high only in IDLE
- baud_div  in  DIV_W  one baud tick every baud_div+1 clk cycles
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  in  1  1 = two stop bits
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress (state != IDLE)
- tx_done  out  1  one-cycle pulse when the final stop bit completes

Behaviour:
- Reset values: tx=1, in_ready=1, busy=0, tx_done=0, state=IDLE, all counters 0.
- Reset mid-frame aborts the frame; tx returns high asynchronously.
- Accept occurs on a clk edge with in_valid && in_ready. At that edge the block latches:
  - in_data into the shift register;
  - baud_div, parity_mode and two_stop into shadow registers.
- Input changes during a frame have no effect on that frame.
- Parity bit is computed at accept:
  - even: XOR of the data bits;
  - odd: inverse of that XOR.
- Baud divider:
  - clk counter reloads to 0 at accept.
  - tick asserts when the counter equals the latched baud_div, and the counter wraps to 0.
  - baud_div=0 gives a tick every clk.
- Each bit lasts exactly OVERSAMPLE ticks, i.e. OVERSAMPLE*(baud_div+1) clk cycles. No off-by-one: the bit counter runs 0..OVERSAMPLE-1.
- tx is registered. It drives 0 (start bit) from the edge after accept.
- FSM:
  - IDLE: on accept → START.
  - START: after 1 bit period → DATA.
  - DATA: DATA_W bit periods, bit index 0..DATA_W-1, LSB first. Then → PARITY if parity enabled, else → STOP.
  - PARITY: 1 bit period → STOP.
  - STOP: tx=1 for 1 bit period, or 2 if two_stop → IDLE.
- tx_done pulses in the cycle the FSM enters IDLE; in_ready goes high that same cycle.
- Frame length in clk cycles = (1 + DATA_W + P + S) * OVERSAMPLE * (baud_div+1), where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back: with in_valid held high, the next accept happens on the IDLE cycle. This leaves exactly one clk of idle-high between frames.
- in_valid while busy is ignored (in_ready=0); the word must be held by the source.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- When defined, adds an input `brk` (1 bit):
  - In IDLE, brk=1 forces tx=0 and holds in_ready=0.
  - Deasserting brk returns tx to 1 on the next edge.
  - brk during a frame is deferred until the frame's stop bit completes.
- When undefined: no port, no logic; behaviour exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10);
  - tx_state_e enum (IDLE, START, DATA, PARITY, STOP);
  - localparams for legal DATA_W bounds.
- The package is shared with the receiver.
- One sub-module, uart_baud_gen (DIV_W), is natural:
  - inputs clk, rst, clear, div;
  - output tick;
  - reused by the receiver.

Test Plan:
- DATA_W=8, OVERSAMPLE=4, baud_div=1, parity none, 1 stop, send 0xA5:
  - tx bits 0,1,0,1,0,0,1,0,1,1, each exactly 8 clk;
  - tx_done 80 clk after the start edge;
  - in_ready low throughout.
- Same config with even parity, send 0x07: parity bit 1, frame 88 clk. Odd parity, send 0x03: parity bit 1. Odd parity, send 0x07: parity bit 0.
- two_stop=1, baud_div=0, OVERSAMPLE=4, send 0xFF: stop high for 8 clk, total frame 44 clk. Change baud_div to 5 mid-frame: timing unchanged.
- in_valid held high with 0x11 then 0x22: two frames separated by exactly 1 idle-high clk; 2 tx_done pulses.
- Assert rst during DATA bit 3: tx=1, busy=0, in_ready=1 immediately. After release, a new 0x5A frame is fully correct.
- With UART_TX_BREAK_EN: brk=1 in IDLE → tx=0 and in_ready=0 for the whole assertion. brk raised mid-frame → frame completes intact, then tx goes low.
